// File: rtl/timer_share_arb.sv
// ---------------------------------------------------------------------------
// timer_share_arb
//   Round-robin arbiter and sequencer that lends one CW-bit interval counter
//   to NREQ requesters. The winner's duration is captured at grant. The
//   counter then runs 0..dur. A one-cycle done pulse goes back to the owner,
//   and then the resource returns to IDLE for re-arbitration.
//
// Ports
//   clk    in   1        clock, all state on rising edge
//   rst    in   1        asynchronous active-high reset
//   req    in   NREQ     level request per requester
//   dur    in   NREQ*CW  duration per requester, slice i = dur[i*CW +: CW]
//   gnt    out  NREQ     one-hot grant, zero when free (registered)
//   owner  out  IW       index of current owner, valid while busy
//   busy   out  1        resource owned (RUN or DONE)
//   count  out  CW       current counter value
//   done   out  NREQ     one-cycle completion pulse to owner (registered)
// ---------------------------------------------------------------------------
module timer_share_arb #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dur,
  output logic [NREQ-1:0]    gnt,
  output logic [IW-1:0]      owner,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [NREQ-1:0]    done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [IW-1:0] ptr_reg;
  logic [CW-1:0] limit_reg;

  // Per-requester duration slices.
  logic [CW-1:0] dur_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dur
    assign dur_arr[gi] = dur[gi*CW +: CW];
  end

  // Round-robin search.
  // Candidates are visited from the farthest position (ptr+NREQ) to the
  // nearest one (ptr+1). Each later hit overrides an earlier one, so the
  // requester closest after the pointer wins.
  logic [IW-1:0] win;
  logic [IW-1:0] cand;

  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr_reg) + k) % NREQ);
      if (req[cand]) begin
        win = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= IW'(NREQ - 1);
      limit_reg <= '0;
      gnt       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      count     <= '0;
      done      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= NREQ'(1) << win;
            owner     <= win;
            busy      <= 1'b1;
            count     <= '0;
            limit_reg <= dur_arr[win];
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort takes precedence over reaching the limit: no done is sent.
          if (!req[owner]) begin
            gnt       <= '0;
            busy      <= 1'b0;
            count     <= '0;
            ptr_reg   <= owner;
            state_reg <= ST_IDLE;
          end else if (count == limit_reg) begin
            done      <= NREQ'(1) << owner;
            state_reg <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          count     <= '0;
          ptr_reg   <= owner;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_arb.sv
// ---------------------------------------------------------------------------
// tb_timer_share_arb
//   Self-checking bench for timer_share_arb. The reference model describes a
//   grant as a tenure. The tenure has an age counted in cycles since the
//   grant and a captured limit. All outputs follow from those two values with
//   plain arithmetic.
// ---------------------------------------------------------------------------
module tb_timer_share_arb;

  localparam int NREQ = 4;
  localparam int CW   = 3;
  localparam int IW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] dur = '0;
  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      owner;
  logic               busy;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  timer_share_arb #(.NREQ(NREQ), .CW(CW), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dur   (dur),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A tenure lasts lim+2 cycles. Ages 0..lim are counting cycles and age
  // lim+1 is the done cycle.
  bit m_busy;
  int m_owner;
  int m_age;
  int m_lim;
  int m_ptr;

  function automatic int pick(int p, logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_age   = 0;
    m_lim   = 0;
    m_ptr   = NREQ - 1;
  endtask

  task automatic model_step();
    int w;
    if (!m_busy) begin
      w = pick(m_ptr, req);
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_age   = 0;
        m_lim   = int'(dur[w*CW +: CW]);
      end
    end else if (m_age == m_lim + 1) begin
      m_busy = 0;
      m_ptr  = m_owner;
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr  = m_owner;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [3:0] g;
    logic [3:0] d;
    int c;
    g = m_busy ? 4'(1 << m_owner) : 4'd0;
    d = (m_busy && m_age == m_lim + 1) ? g : 4'd0;
    c = m_busy ? ((m_age > m_lim) ? m_lim : m_age) : 0;
    return {g, d, m_busy, 3'(c), m_busy ? 2'(m_owner) : 2'd0};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {gnt, done, busy, count, busy ? owner : 2'd0};
  endfunction

  // The model advances with the inputs that are present before the edge.
  // Outputs are then sampled 1 ns after the edge.
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    dur = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec() || obs_vec() !== 14'd0) begin
        failed++;
        $display("FAIL reset cyc%0d got %h want %h", i, obs_vec(), 14'd0);
      end
    end
    req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int gnt_cycles = 0;
    int done_cnt   = 0;
    int done_at    = -1;
    do_reset();
    req = 4'b0001;
    dur = 12'd3;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) req = '0;
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL single cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (gnt[0]) gnt_cycles++;
      if (done[0]) begin
        done_cnt++;
        done_at = int'(count);
      end
    end
    compared++;
    if (gnt_cycles != 5 || done_cnt != 1 || done_at != 3) begin
      failed++;
      $display("FAIL single_totals got gnt=%0d done=%0d at=%0d want 5 1 3",
               gnt_cycles, done_cnt, done_at);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int done_cnt = 0;
    logic [NREQ-1:0] prev = '0;
    do_reset();
    req = 4'b1111;
    dur = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL rr cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (gnt != 0 && prev == 0) order.push_back(int'(owner));
      if (done != 0) done_cnt++;
      prev = gnt;
    end
    req = '0;
    compared++;
    if (order.size() != 5 || done_cnt != 5) begin
      failed++;
      $display("FAIL rr_count got grants=%0d dones=%0d want 5 5", order.size(), done_cnt);
    end else begin
      for (int k = 0; k < 5; k++) begin
        compared++;
        if (order[k] != exp_order[k]) begin
          failed++;
          $display("FAIL rr_order[%0d] got %0d want %0d", k, order[k], exp_order[k]);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_long_dur();
    int max_cnt = 0;
    int done_cnt = 0;
    do_reset();
    req = 4'b0100;
    dur = {3'd0, 3'd7, 3'd0, 3'd0};
    for (int i = 0; i < 12; i++) begin
      if (i == 10) req = '0;
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL long cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (busy && int'(count) > max_cnt) max_cnt = int'(count);
      if (done[2]) done_cnt++;
      // Changing the duration while the counter runs must have no effect.
      if (busy && count == 3'd3) dur = '0;
    end
    compared++;
    if (max_cnt != 7 || done_cnt != 1) begin
      failed++;
      $display("FAIL long_totals got max=%0d done=%0d want 7 1", max_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    int order[$];
    int done1 = 0;
    logic [NREQ-1:0] prev = '0;
    do_reset();
    req = 4'b0110;
    dur = {3'd0, 3'd1, 3'd5, 3'd0};
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req = '0;
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL abort cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (gnt != 0 && prev == 0) order.push_back(int'(owner));
      if (done[1]) done1++;
      prev = gnt;
      if (gnt[1] && count == 3'd2) req[1] = 1'b0;
    end
    compared++;
    if (order.size() < 2 || order[0] != 1 || order[1] != 2 || done1 != 0) begin
      failed++;
      $display("FAIL abort_seq got grants=%0d first=%0d second=%0d done1=%0d want 1 2 0",
               order.size(), order.size() > 0 ? order[0] : -1,
               order.size() > 1 ? order[1] : -1, done1);
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    do_reset();
    req = 4'b0001;
    dur = 12'd5;
    for (int i = 0; i < 12 && !hit; i++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL arst_pre cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (busy && count == 3'd3) hit = 1;
    end
    compared++;
    if (!hit) begin
      failed++;
      $display("FAIL arst_wait got no count=3 want count=3 within 12 cycles");
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({gnt, busy, count, done} !== 12'd0) begin
      failed++;
      $display("FAIL arst_immediate got %h want %h", {gnt, busy, count, done}, 12'd0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL arst_post cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        compared++;
        if (gnt !== 4'b0001 || count !== 3'd0) begin
          failed++;
          $display("FAIL arst_regrant got gnt=%b cnt=%0d want 0001 0", gnt, count);
        end
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_abort_at_limit();
    int done_cnt = 0;
    do_reset();
    req = 4'b0001;
    dur = 12'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL abort_lim cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (done != 0) done_cnt++;
      if (gnt[0] && count == 3'd1) req = '0;
    end
    compared++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL abort_lim_done got done=%0d busy=%b want 0 0", done_cnt, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) req = NREQ'($urandom);
      dur = (NREQ * CW)'($urandom);
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL random cyc%0d req=%b got %h want %h", i, req, obs_vec(), exp_vec());
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_long_dur();
    test_abort();
    test_async_reset();
    test_abort_at_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
